// File: rtl/des_pkg.sv
// des_pkg: DES output-stage constants, permutation tables and FSM encoding.
// Bit numbering follows FIPS 46-3: bit 1 is the most significant bit of a block.
package des_pkg;

    localparam int BLOCK_W         = 64;
    localparam int HALF_W          = 32;
    localparam int BYTES_PER_BLOCK = 8;
    localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

    localparam int FP_TBL [BLOCK_W] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int IP_TBL [BLOCK_W] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fsm_e;

    // FIPS bit n lives at vector position BLOCK_W+1-n.
    function automatic logic [BLOCK_W:1] permute_fp(input logic [BLOCK_W:1] d);
        logic [BLOCK_W:1] r;
        r = '0;
        for (int i = 1; i <= BLOCK_W; i++) begin
            r[BLOCK_W + 1 - i] = d[BLOCK_W + 1 - FP_TBL[i - 1]];
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W:1] permute_ip(input logic [BLOCK_W:1] d);
        logic [BLOCK_W:1] r;
        r = '0;
        for (int i = 1; i <= BLOCK_W; i++) begin
            r[BLOCK_W + 1 - i] = d[BLOCK_W + 1 - IP_TBL[i - 1]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_inv_perm.sv
// des_inv_perm: combinational IP^-1 mapping of a 64-bit preoutput block.
// Pure wiring; no state.
module des_inv_perm
    import des_pkg::*;
(
    input  logic [BLOCK_W:1] i_pre,
    output logic [BLOCK_W:1] o_cipher
);

    assign o_cipher = permute_fp(i_pre);

endmodule

// File: rtl/des_final_permutation_tx.sv
// des_final_permutation_tx: IP^-1 output stage with one hold slot and byte serializer.
// Define DES_FP_SELFCHECK_EN to add the sticky PERM_ERR round-trip check.
module des_final_permutation_tx
    import des_pkg::*;
#(
    parameter int COUNT_W    = 16,
    parameter int HOLD_DEPTH = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [32:1]        L16,
    input  logic [32:1]        R16,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [7:0]         OUT_BYTE,
    output logic               OUT_LAST,
    output logic [64:1]        CIPHER,
    output logic [COUNT_W-1:0] BLOCK_COUNT
`ifdef DES_FP_SELFCHECK_EN
    ,
    output logic               PERM_ERR
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

    logic [BLOCK_W:1]   w_pre;
    logic [BLOCK_W:1]   w_perm;
    logic [BLOCK_W:1]   r_hold_c;
    logic [BLOCK_W:1]   r_shreg;
    logic [BLOCK_W:1]   r_cipher;
    logic               r_hold_full;
    logic [IDX_W-1:0]   r_idx;
    logic [COUNT_W-1:0] r_count;
    fsm_e               r_state;
    fsm_e               w_state_nxt;
    logic               w_slot_free;
    logic               w_in_fire;
    logic               w_load;
    logic               w_shift;
    logic               w_done;

    assign w_pre = {R16, L16};

    des_inv_perm u_inv_perm (
        .i_pre    (w_pre),
        .o_cipher (w_perm)
    );

    assign w_slot_free = (int'(r_hold_full) < HOLD_DEPTH);
    assign IN_READY    = w_slot_free & ~RESET;
    assign w_in_fire   = IN_VALID & IN_READY;

    assign OUT_VALID   = (r_state == ST_SEND);
    assign OUT_LAST    = OUT_VALID & (r_idx == LAST_IDX);
    assign OUT_BYTE    = r_shreg[BLOCK_W -: 8];
    assign CIPHER      = r_cipher;
    assign BLOCK_COUNT = r_count;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (OUT_READY) begin
                    if (r_idx == LAST_IDX) begin
                        w_done = 1'b1;
                        // A waiting block reloads now so the next byte 0 follows without a bubble.
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hold_full <= 1'b0;
            r_hold_c    <= '0;
            r_shreg     <= '0;
            r_cipher    <= '0;
            r_idx       <= '0;
            r_count     <= '0;
        end else begin
            if (w_in_fire) begin
                r_hold_full <= 1'b1;
                r_hold_c    <= w_perm;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shreg  <= r_hold_c;
                r_cipher <= r_hold_c;
                r_idx    <= '0;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[BLOCK_W-8:1], 8'h00};
                r_idx   <= r_idx + IDX_W'(1);
            end

            if (w_done) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

`ifdef DES_FP_SELFCHECK_EN
    logic [BLOCK_W:1] r_hold_p;
    logic             r_perm_err;

    assign PERM_ERR = r_perm_err;

    // Applying IP to the held ciphertext must give back the preoutput it came from.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hold_p   <= '0;
            r_perm_err <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_hold_p <= w_pre;
            end
            if (w_load && (permute_ip(r_hold_c) != r_hold_p)) begin
                r_perm_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_des_final_permutation_tx.sv
// tb_des_final_permutation_tx: directed vectors for the DES IP^-1 byte streamer.
// Exercises latency, back-to-back, backpressure, mid-block reset and counter wrap.
module tb_des_final_permutation_tx;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [32:1]   L16 = '0;
    logic [32:1]   R16 = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [7:0]    OUT_BYTE;
    logic          OUT_LAST;
    logic [64:1]   CIPHER;
    logic [CW-1:0] BLOCK_COUNT;
`ifdef DES_FP_SELFCHECK_EN
    logic          PERM_ERR;
`endif

    des_final_permutation_tx #(
        .COUNT_W    (CW),
        .HOLD_DEPTH (1)
    ) u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .L16         (L16),
        .R16         (R16),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_BYTE    (OUT_BYTE),
        .OUT_LAST    (OUT_LAST),
        .CIPHER      (CIPHER),
        .BLOCK_COUNT (BLOCK_COUNT)
`ifdef DES_FP_SELFCHECK_EN
        ,
        .PERM_ERR    (PERM_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          n_stalls = 0;
    logic [7:0]  q_byte[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_byte;
    logic        prev_last;
    logic [64:1] prev_cipher;

    logic [31:0] vl[8];
    logic [31:0] vr[8];
    logic [63:0] vc[8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #2;
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'($urandom_range(0, 1));
            default: OUT_READY = 1'b0;
        endcase
    end

    always @(negedge CLK) begin
        if (RESET) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_stalls++;
                check("stall_valid", OUT_VALID, 1'b1);
                check("stall_byte", OUT_BYTE, prev_byte);
                check("stall_last", OUT_LAST, prev_last);
                check("stall_cipher", CIPHER, prev_cipher);
            end
            if (OUT_VALID && OUT_READY) begin
                q_byte.push_back(OUT_BYTE);
                q_last.push_back(OUT_LAST);
                q_cyc.push_back(cyc);
            end
            stall_prev  = OUT_VALID && !OUT_READY;
            prev_byte   = OUT_BYTE;
            prev_last   = OUT_LAST;
            prev_cipher = CIPHER;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic put_block(input logic [31:0] l, input logic [31:0] r);
        int b;
        b = 0;
        L16 = l;
        R16 = r;
        IN_VALID = 1'b1;
        while (!IN_READY && b < 200) begin
            tick(1);
            b++;
        end
        check("in_ready_wait", IN_READY, 1'b1);
        tick(1);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int b;
        b = 0;
        while (q_byte.size() < n && b < 2500) begin
            tick(1);
            b++;
        end
        check("byte_wait", q_byte.size() >= n, 1'b1);
    endtask

    task automatic expect_block(input string tag, input logic [63:0] c);
        logic [63:0] cv;
        logic [7:0]  eb;
        cv = c;
        wait_bytes(8);
        for (int k = 0; k < 8; k++) begin
            eb = cv[63 - 8*k -: 8];
            if (q_byte.size() > 0) begin
                check({tag, "_byte"}, q_byte.pop_front(), eb);
                check({tag, "_last"}, q_last.pop_front(), k == 7);
                void'(q_cyc.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        q_byte.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    initial begin
        vl[0] = 32'h43423234; vr[0] = 32'h0A4CD995; vc[0] = 64'h85E813540F0AB405;
        vl[1] = 32'h00000000; vr[1] = 32'h00000000; vc[1] = 64'h0000000000000000;
        vl[2] = 32'hFFFFFFFF; vr[2] = 32'hFFFFFFFF; vc[2] = 64'hFFFFFFFFFFFFFFFF;
        vl[3] = 32'h00000000; vr[3] = 32'h80000000; vc[3] = 64'h0000000000000040;
        vl[4] = 32'h00000001; vr[4] = 32'h00000000; vc[4] = 64'h0200000000000000;
        vl[5] = 32'h00000000; vr[5] = 32'h00000001; vc[5] = 64'h0100000000000000;
        vl[6] = 32'h80000000; vr[6] = 32'h00000000; vc[6] = 64'h0000000000000080;
        vl[7] = 32'h00000000; vr[7] = 32'h40000000; vc[7] = 64'h0000000000004000;

        // reset state
        tick(2);
        check("rst_in_ready", IN_READY, 1'b0);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_out_last", OUT_LAST, 1'b0);
        check("rst_out_byte", OUT_BYTE, 8'h00);
        check("rst_cipher", CIPHER, 64'h0);
        check("rst_count", BLOCK_COUNT, '0);
        RESET = 1'b0;
        tick(1);
        check("post_rst_in_ready", IN_READY, 1'b1);

        // known vector with latency
        put_block(vl[0], vr[0]);
        check("lat_cycle1_valid", OUT_VALID, 1'b0);
        tick(1);
        check("lat_cycle2_valid", OUT_VALID, 1'b1);
        check("known_cipher", CIPHER, vc[0]);
        expect_block("known", vc[0]);
        tick(1);
        check("known_count", BLOCK_COUNT, CW'(1));

        // back-to-back
        put_block(vl[2], vr[2]);
        put_block(vl[3], vr[3]);
        check("b2b_slot_full", IN_READY, 1'b0);
        wait_bytes(16);
        if (q_cyc.size() >= 16) begin
            check("b2b_span", q_cyc[15] - q_cyc[0], 15);
        end
        check("b2b_slot_free", IN_READY, 1'b1);
        expect_block("b2b_a", vc[2]);
        expect_block("b2b_b", vc[3]);
        tick(1);
        check("b2b_count", BLOCK_COUNT, CW'(3));

        // random backpressure, third block refused while both stages busy
        rdy_mode = 1;
        put_block(vl[4], vr[4]);
        put_block(vl[5], vr[5]);
        L16 = vl[6];
        R16 = vr[6];
        IN_VALID = 1'b1;
        check("third_refused", IN_READY, 1'b0);
        put_block(vl[6], vr[6]);
        expect_block("bp_a", vc[4]);
        expect_block("bp_b", vc[5]);
        expect_block("bp_c", vc[6]);
        rdy_mode = 0;
        tick(2);
        check("bp_stalls_seen", n_stalls > 0, 1'b1);
        check("bp_count", BLOCK_COUNT, CW'(6));

        // full stall then release
        rdy_mode = 2;
        put_block(vl[7], vr[7]);
        tick(5);
        check("hold_valid", OUT_VALID, 1'b1);
        check("hold_cipher", CIPHER, vc[7]);
        check("hold_byte", OUT_BYTE, 8'h00);
        rdy_mode = 0;
        expect_block("hold", vc[7]);
        tick(1);
        check("hold_count", BLOCK_COUNT, CW'(7));

        // reset mid-block
        put_block(vl[0], vr[0]);
        begin
            int b;
            b = 0;
            while (q_byte.size() < 3 && b < 100) begin
                tick(1);
                b++;
            end
        end
        check("mid_three_bytes", q_byte.size(), 3);
        RESET = 1'b1;
        tick(1);
        check("mid_rst_valid", OUT_VALID, 1'b0);
        check("mid_rst_count", BLOCK_COUNT, '0);
        check("mid_rst_in_ready", IN_READY, 1'b0);
        RESET = 1'b0;
        q_byte.delete();
        q_last.delete();
        q_cyc.delete();
        tick(1);
        put_block(vl[0], vr[0]);
        expect_block("after_rst", vc[0]);
        tick(1);
        check("after_rst_count", BLOCK_COUNT, CW'(1));

        // counter wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            put_block(vl[i % 8], vr[i % 8]);
        end
        wait_bytes(128);
        tick(2);
        check("wrap16_count", BLOCK_COUNT, CW'(0));
        put_block(vl[0], vr[0]);
        wait_bytes(136);
        tick(2);
        check("wrap17_count", BLOCK_COUNT, CW'(1));
        q_byte.delete();
        q_last.delete();
        q_cyc.delete();

`ifdef DES_FP_SELFCHECK_EN
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            put_block($urandom, $urandom);
            q_byte.delete();
            q_last.delete();
            q_cyc.delete();
        end
        tick(20);
        check("perm_err_clean", PERM_ERR, 1'b0);
        force u_dut.w_perm = 64'h85E813540F0AB404;
        put_block(vl[0], vr[0]);
        release u_dut.w_perm;
        tick(20);
        check("perm_err_set", PERM_ERR, 1'b1);
        put_block(vl[1], vr[1]);
        tick(20);
        check("perm_err_sticky", PERM_ERR, 1'b1);
        q_byte.delete();
        q_last.delete();
        q_cyc.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
